wb_arb2_ctrl: RTL and testbench

//  Two-master Wishbone arbiter/sequencer sharing one slave port (e.g. ddr0 between lm32i and lm32d).

---
 rtl/wb_arb2_ctrl.sv | 170 +++++++++++++++++
 tb/tb_wb_arb2_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arb2_ctrl.sv
// Two-master Wishbone arbiter: round-robin grant held for a whole bus cycle.
// Define WB_ARB_TIMEOUT_EN to add a watchdog that aborts transfers the slave never answers.
module wb_arb2_ctrl #(
   parameter int unsigned adr_width      = 32,
   parameter int unsigned timeout_cycles = 1023
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 m0_cyc_i,
   input  logic                 m0_stb_i,
   input  logic                 m0_we_i,
   input  logic [adr_width-1:0] m0_adr_i,
   input  logic [31:0]          m0_dat_i,
   input  logic [3:0]           m0_sel_i,
   output logic [31:0]          m0_dat_o,
   output logic                 m0_ack_o,
   output logic                 m0_err_o,
   input  logic                 m1_cyc_i,
   input  logic                 m1_stb_i,
   input  logic                 m1_we_i,
   input  logic [adr_width-1:0] m1_adr_i,
   input  logic [31:0]          m1_dat_i,
   input  logic [3:0]           m1_sel_i,
   output logic [31:0]          m1_dat_o,
   output logic                 m1_ack_o,
   output logic                 m1_err_o,
   output logic                 s_cyc_o,
   output logic                 s_stb_o,
   output logic                 s_we_o,
   output logic [adr_width-1:0] s_adr_o,
   output logic [31:0]          s_dat_o,
   output logic [3:0]           s_sel_o,
   input  logic [31:0]          s_dat_i,
   input  logic                 s_ack_i,
   input  logic                 s_err_i
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] GNT0  = 2'd1;
   localparam logic [1:0] GNT1  = 2'd2;
`ifdef WB_ARB_TIMEOUT_EN
   localparam logic [1:0] ABORT = 2'd3;
`endif

   if (timeout_cycles == 0 || timeout_cycles > 65535) begin : g_bad_timeout
      $error("wb_arb2_ctrl: timeout_cycles must be 1..65535");
   end

   logic [1:0] state, state_nxt;
   logic       last, last_nxt;
   logic       gnt_cyc, gnt_stb;
   logic       expire;

   always_comb begin
      gnt_cyc = 1'b0;
      gnt_stb = 1'b0;
      if (state == GNT0) begin
         gnt_cyc = m0_cyc_i;
         gnt_stb = m0_stb_i;
      end else if (state == GNT1) begin
         gnt_cyc = m1_cyc_i;
         gnt_stb = m1_stb_i;
      end
   end

`ifdef WB_ARB_TIMEOUT_EN
   logic [15:0] cnt, cnt_nxt;

   // Fires in the last permitted wait cycle, only if the slave stays silent in it too.
   assign expire = gnt_cyc && gnt_stb && !s_ack_i && !s_err_i
                   && (cnt == 16'(timeout_cycles - 1));

   always_comb begin
      cnt_nxt = cnt;
      if ((state_nxt == GNT0 || state_nxt == GNT1) && state_nxt != state)
         cnt_nxt = '0;
      else if (s_ack_i || s_err_i)
         cnt_nxt = '0;
      else if (gnt_stb && cnt != '1)
         cnt_nxt = cnt + 16'd1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) cnt <= '0;
      else          cnt <= cnt_nxt;
   end
`else
   assign expire = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (m0_cyc_i && m1_cyc_i) state_nxt = last ? GNT0 : GNT1;
            else if (m0_cyc_i)        state_nxt = GNT0;
            else if (m1_cyc_i)        state_nxt = GNT1;
         end
         GNT0: begin
            if (!m0_cyc_i)   state_nxt = m1_cyc_i ? GNT1 : IDLE;
`ifdef WB_ARB_TIMEOUT_EN
            else if (expire) state_nxt = ABORT;
`endif
         end
         GNT1: begin
            if (!m1_cyc_i)   state_nxt = m0_cyc_i ? GNT0 : IDLE;
`ifdef WB_ARB_TIMEOUT_EN
            else if (expire) state_nxt = ABORT;
`endif
         end
`ifdef WB_ARB_TIMEOUT_EN
         // last still names the aborted master, so wait for that one to drop cyc.
         ABORT: if (!(last ? m1_cyc_i : m0_cyc_i)) state_nxt = IDLE;
`endif
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      last_nxt = last;
      if (state_nxt == GNT0)      last_nxt = 1'b0;
      else if (state_nxt == GNT1) last_nxt = 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         last  <= 1'b1;
      end else begin
         state <= state_nxt;
         last  <= last_nxt;
      end
   end

   assign m0_dat_o = s_dat_i;
   assign m1_dat_o = s_dat_i;

   always_comb begin
      s_cyc_o  = 1'b0;
      s_stb_o  = 1'b0;
      s_we_o   = 1'b0;
      s_adr_o  = '0;
      s_dat_o  = '0;
      s_sel_o  = '0;
      m0_ack_o = 1'b0;
      m0_err_o = 1'b0;
      m1_ack_o = 1'b0;
      m1_err_o = 1'b0;
      if (state == GNT0) begin
         s_cyc_o  = m0_cyc_i && !expire;
         s_stb_o  = m0_stb_i && !expire;
         s_we_o   = m0_we_i;
         s_adr_o  = m0_adr_i;
         s_dat_o  = m0_dat_i;
         s_sel_o  = m0_sel_i;
         m0_ack_o = s_ack_i;
         m0_err_o = s_err_i || expire;
      end else if (state == GNT1) begin
         s_cyc_o  = m1_cyc_i && !expire;
         s_stb_o  = m1_stb_i && !expire;
         s_we_o   = m1_we_i;
         s_adr_o  = m1_adr_i;
         s_dat_o  = m1_dat_i;
         s_sel_o  = m1_sel_i;
         m1_ack_o = s_ack_i;
         m1_err_o = s_err_i || expire;
      end
   end

endmodule

// File: tb/tb_wb_arb2_ctrl.sv
// Randomized bench for wb_arb2_ctrl against a transaction-level ownership model.
module tb_wb_arb2_ctrl;

   localparam int TO = 16;
`ifdef WB_ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        cyc [2];
   logic        stb [2];
   logic        we  [2];
   logic [31:0] adr [2];
   logic [31:0] dat [2];
   logic [3:0]  sel [2];
   logic [31:0] m0_dat_o, m1_dat_o;
   logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
   logic        s_cyc_o, s_stb_o, s_we_o;
   logic [31:0] s_adr_o, s_dat_o;
   logic [3:0]  s_sel_o;
   logic [31:0] s_dat_i = '0;
   logic        s_ack_i = 1'b0;
   logic        s_err_i = 1'b0;

   int n_checks = 0;
   int n_errors = 0;

   // Model: who owns the bus (-1 = nobody), whether that ownership was aborted,
   // who was granted last, and how many strobed cycles have gone unanswered.
   int owner = -1;
   bit aborted = 1'b0;
   int last_owner = 1;
   int wait_cnt = 0;

   always #5 clk = ~clk;

   wb_arb2_ctrl #(.adr_width(32), .timeout_cycles(TO)) dut (
      .clk(clk), .reset_n(reset_n),
      .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_we_i(we[0]), .m0_adr_i(adr[0]),
      .m0_dat_i(dat[0]), .m0_sel_i(sel[0]), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
      .m0_err_o(m0_err_o),
      .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_we_i(we[1]), .m1_adr_i(adr[1]),
      .m1_dat_i(dat[1]), .m1_sel_i(sel[1]), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
      .m1_err_o(m1_err_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
      .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
      .s_err_i(s_err_i)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         if (n_errors <= 30)
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
      end
   endtask

   function automatic void model_reset();
      owner = -1;
      aborted = 1'b0;
      last_owner = 1;
      wait_cnt = 0;
   endfunction

   // Called at a falling edge with inputs already driven; compares, then advances the model.
   task automatic cycle();
      logic        e_cyc, e_stb, e_we, expire;
      logic [31:0] e_adr, e_dat;
      logic [3:0]  e_sel;
      logic        e_ack [2];
      logic        e_err [2];
      int          other;
      #1;
      e_cyc = 0; e_stb = 0; e_we = 0; e_adr = 0; e_dat = 0; e_sel = 0;
      e_ack[0] = 0; e_ack[1] = 0; e_err[0] = 0; e_err[1] = 0;
      expire = 0;
      if (reset_n && owner >= 0 && !aborted) begin
         expire = TO_EN && cyc[owner] && stb[owner] && !s_ack_i && !s_err_i
                  && (wait_cnt == TO - 1);
         e_cyc = cyc[owner] && !expire;
         e_stb = stb[owner] && !expire;
         e_we  = we[owner];
         e_adr = adr[owner];
         e_dat = dat[owner];
         e_sel = sel[owner];
         e_ack[owner] = s_ack_i;
         e_err[owner] = s_err_i || expire;
      end
      check_eq("s_cyc", 32'(s_cyc_o), 32'(e_cyc));
      check_eq("s_stb", 32'(s_stb_o), 32'(e_stb));
      check_eq("s_we", 32'(s_we_o), 32'(e_we));
      check_eq("s_adr", s_adr_o, e_adr);
      check_eq("s_dat", s_dat_o, e_dat);
      check_eq("s_sel", 32'(s_sel_o), 32'(e_sel));
      check_eq("m0_ack", 32'(m0_ack_o), 32'(e_ack[0]));
      check_eq("m0_err", 32'(m0_err_o), 32'(e_err[0]));
      check_eq("m1_ack", 32'(m1_ack_o), 32'(e_ack[1]));
      check_eq("m1_err", 32'(m1_err_o), 32'(e_err[1]));
      check_eq("m0_dat", m0_dat_o, s_dat_i);
      check_eq("m1_dat", m1_dat_o, s_dat_i);

      @(posedge clk);
      if (!reset_n) model_reset();
      else if (owner < 0) begin
         if (cyc[0] && cyc[1]) owner = 1 - last_owner;
         else if (cyc[0])      owner = 0;
         else if (cyc[1])      owner = 1;
         if (owner >= 0) begin
            last_owner = owner;
            wait_cnt = 0;
         end
      end else if (aborted) begin
         if (!cyc[owner]) begin
            owner = -1;
            aborted = 1'b0;
         end
      end else if (!cyc[owner]) begin
         other = 1 - owner;
         if (cyc[other]) begin
            owner = other;
            last_owner = other;
            wait_cnt = 0;
         end else owner = -1;
      end else if (expire) aborted = 1'b1;
      else if (s_ack_i || s_err_i) wait_cnt = 0;
      else if (stb[owner] && wait_cnt < 65535) wait_cnt++;
      @(negedge clk);
   endtask

   task automatic set_master(input int m, input logic c, input logic s, input logic [31:0] a);
      cyc[m] = c;
      stb[m] = s;
      we[m]  = $urandom_range(0, 1) == 1;
      adr[m] = a;
      dat[m] = $urandom;
      sel[m] = 4'($urandom);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int ack_pct;
      for (int m = 0; m < 2; m++) set_master(m, 1'b0, 1'b0, 32'h0);

      // Reset state
      @(negedge clk);
      check_eq("rst_s_cyc", 32'(s_cyc_o), 32'd0);
      check_eq("rst_s_adr", s_adr_o, 32'd0);
      check_eq("rst_m0_ack", 32'(m0_ack_o), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
      cycle();

      // Simultaneous requests out of reset: m0 first, then m1 with no idle gap
      set_master(0, 1'b1, 1'b1, 32'h0000_00A0);
      set_master(1, 1'b1, 1'b1, 32'h0000_00B1);
      cycle();
      #1 check_eq("tie_first_m0", s_adr_o, 32'h0000_00A0);
      cycle();
      set_master(0, 1'b0, 1'b0, 32'h0);
      cycle();
      #1 check_eq("handoff_m1_cyc", 32'(s_cyc_o), 32'd1);
      check_eq("handoff_m1_adr", s_adr_o, 32'h0000_00B1);
      set_master(1, 1'b0, 1'b0, 32'h0);
      cycle();
      cycle();
      set_master(0, 1'b1, 1'b1, 32'h0000_00A2);
      set_master(1, 1'b1, 1'b1, 32'h0000_00B2);
      cycle();
      #1 check_eq("tie_again_m0", s_adr_o, 32'h0000_00A2);
      set_master(0, 1'b0, 1'b0, 32'h0);
      set_master(1, 1'b0, 1'b0, 32'h0);
      cycle();

      // m1 burst of 4 acked beats while m0 waits
      set_master(1, 1'b1, 1'b0, 32'h0000_1000);
      cycle();
      set_master(0, 1'b1, 1'b1, 32'h0000_2000);
      for (int b = 0; b < 4; b++) begin
         set_master(1, 1'b1, 1'b1, 32'h0000_1000 + 32'(b * 4));
         s_ack_i = 1'b0;
         cycle();
         s_ack_i = 1'b1;
         s_dat_i = $urandom;
         #1 check_eq("burst_m1_adr", s_adr_o, 32'h0000_1000 + 32'(b * 4));
         cycle();
      end
      s_ack_i = 1'b0;
      set_master(1, 1'b0, 1'b0, 32'h0);
      cycle();
      #1 check_eq("burst_then_m0", s_adr_o, 32'h0000_2000);
      set_master(0, 1'b0, 1'b0, 32'h0);
      cycle();

      // Random traffic with varying slave responsiveness
      for (int blk = 0; blk < 16; blk++) begin
         case (blk % 4)
            0: ack_pct = 0;
            1: ack_pct = 10;
            2: ack_pct = 50;
            default: ack_pct = 90;
         endcase
         for (int i = 0; i < 200; i++) begin
            for (int m = 0; m < 2; m++) begin
               logic c;
               c = cyc[m] ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 3) == 0);
               set_master(m, c, c && ($urandom_range(0, 3) != 0), $urandom);
            end
            s_ack_i = $urandom_range(0, 99) < ack_pct;
            s_err_i = $urandom_range(0, 99) < 3;
            s_dat_i = $urandom;
            cycle();
         end
      end
      for (int m = 0; m < 2; m++) set_master(m, 1'b0, 1'b0, 32'h0);
      s_ack_i = 1'b0;
      s_err_i = 1'b0;
      cycle();
      cycle();

      // Dead slave for a long stretch while m1 also waits, then an error
      set_master(0, 1'b1, 1'b1, 32'h0000_3000);
      cycle();
      set_master(1, 1'b1, 1'b1, 32'h0000_4000);
      for (int i = 0; i < 5000; i++) cycle();
      s_err_i = 1'b1;
      cycle();
      s_err_i = 1'b0;
      set_master(0, 1'b0, 1'b0, 32'h0);
      cycle();
      cycle();
      cycle();

      // Asynchronous reset in the middle of an m1 burst
      s_ack_i = 1'b1;
      cycle();
      #2 reset_n = 1'b0;
      #1;
      check_eq("arst_s_cyc", 32'(s_cyc_o), 32'd0);
      check_eq("arst_s_stb", 32'(s_stb_o), 32'd0);
      check_eq("arst_s_adr", s_adr_o, 32'd0);
      check_eq("arst_m1_ack", 32'(m1_ack_o), 32'd0);
      model_reset();
      @(negedge clk);
      s_ack_i = 1'b0;
      cycle();
      reset_n = 1'b1;
      set_master(0, 1'b1, 1'b1, 32'h0000_5000);
      set_master(1, 1'b1, 1'b1, 32'h0000_6000);
      cycle();
      #1 check_eq("post_rst_m0", s_adr_o, 32'h0000_5000);
      cycle();
      for (int m = 0; m < 2; m++) set_master(m, 1'b0, 1'b0, 32'h0);
      cycle();
      cycle();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
